// File: rtl/bt_uart_tx.sv
// bt_uart_tx: 8N1 UART transmitter with a small byte FIFO, driving the HC-06 RXD pin.
// Optional macro BT_TX_PARITY_EN inserts an even-parity bit after D7 (8E1 frame).
module bt_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          tx
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int CNT_W  = $clog2(DIV);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

`ifdef BT_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FCNT_W-1:0] count_r;
  logic [FCNT_W-1:0] count_n_s;
  logic              full_r;
  logic              push_s;
  logic              pop_s;
  logic              empty_s;
  logic [7:0]        pop_data_s;

  // Serializer state
  state_t            state_r;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_n;
  logic [2:0]        bit_r;
  logic [2:0]        bit_n;
  logic [7:0]        shift_r;
  logic [7:0]        shift_n;
  logic              tx_r;
  logic              tx_n;
  logic              busy_r;
  logic              busy_n;
  logic              bit_end_s;
`ifdef BT_TX_PARITY_EN
  logic              par_r;
  logic              par_n;
`endif

  // A write is refused whenever the registered full flag is set, even if a pop frees a slot this edge
  assign push_s     = wr_en & ~full_r;
  assign empty_s    = (count_r == FCNT_W'(0));
  assign pop_data_s = mem[rd_ptr_r];
  assign bit_end_s  = (cnt_r == CNT_W'(DIV - 1));

  // Next FIFO occupancy from the push/pop pair
  always_comb begin
    count_n_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + FCNT_W'(1);
      2'b01:   count_n_s = count_r - FCNT_W'(1);
      default: count_n_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and full flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {FCNT_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_n_s;
      full_r  <= (count_n_s == FCNT_W'(FIFO_DEPTH));
    end
  end

  // FIFO data array; contents are don't-care once the pointers are flushed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem[wr_ptr_r] <= wr_data;
    end
  end

  // Frame sequencing, baud counting and next line level
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r + CNT_W'(1);
    bit_n   = bit_r;
    shift_n = shift_r;
    pop_s   = 1'b0;
`ifdef BT_TX_PARITY_EN
    par_n   = par_r;
`endif

    case (state_r)
      ST_IDLE: begin
        cnt_n = CNT_W'(0);
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_n = pop_data_s;
`ifdef BT_TX_PARITY_EN
          par_n   = even_parity(pop_data_s);
`endif
          state_n = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          cnt_n   = CNT_W'(0);
          bit_n   = 3'd0;
          state_n = ST_DATA;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          cnt_n = CNT_W'(0);
          if (bit_r == 3'd7) begin
`ifdef BT_TX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end else begin
            bit_n   = bit_r + 3'd1;
            shift_n = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_n = ST_DATA;
        end
      end
`ifdef BT_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          cnt_n   = CNT_W'(0);
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          cnt_n = CNT_W'(0);
          // Chain straight into the next start bit when more bytes are waiting
          if (!empty_s) begin
            pop_s   = 1'b1;
            shift_n = pop_data_s;
`ifdef BT_TX_PARITY_EN
            par_n   = even_parity(pop_data_s);
`endif
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        cnt_n   = CNT_W'(0);
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
`ifdef BT_TX_PARITY_EN
      ST_PARITY: tx_n = par_n;
`endif
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Serializer registers; tx and busy come straight from flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
`ifdef BT_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      tx_r    <= tx_n;
      busy_r  <= busy_n;
`ifdef BT_TX_PARITY_EN
      par_r   <= par_n;
`endif
    end
  end

  assign full       = full_r;
  assign fifo_count = count_r;
  assign busy       = busy_r;
  assign tx         = tx_r;

endmodule

// File: tb/tb_bt_uart_tx.sv
// Self-checking bench for bt_uart_tx at DIV=16; a frame-level model predicts the line every cycle.
module tb_bt_uart_tx;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int DIV    = 16;
  localparam int DEPTH  = 4;
`ifdef BT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic [2:0] fifo_count;
  logic       busy;
  logic       tx;

  int checks = 0;
  int errors = 0;

  // model: queued bytes, the frame on the line and its start edge
  byte unsigned mq[$];
  logic       m_active = 1'b0;
  int         fr_start = 0;
  logic [7:0] fr_data = 8'h00;
  int         edge_no = 0;
  logic       e_tx, e_busy, e_full;
  logic [2:0] e_count;

  bt_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .fifo_count(fifo_count), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // line level for bit slot k of a frame carrying d
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[k-1];
    else if (k == 9 && NB == 11) return ^d;
    else return 1'b1;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_active = 1'b0;
  endtask

  // one clock: drive inputs, advance the model, settle just after the edge
  task automatic step(input logic we, input logic [7:0] wd);
    int nb;
    @(negedge clk);
    wr_en = we;
    wr_data = wd;
    @(posedge clk);
    edge_no++;
    nb = mq.size();
    if (m_active && (edge_no - fr_start) == NB * DIV) m_active = 1'b0;
    if (!m_active && nb > 0) begin
      fr_data = mq.pop_front();
      fr_start = edge_no;
      m_active = 1'b1;
    end
    if (we && nb < DEPTH) mq.push_back(wd);
    #1;
    e_tx    = m_active ? frame_bit(fr_data, (edge_no - fr_start) / DIV) : 1'b1;
    e_busy  = m_active;
    e_count = 3'(mq.size());
    e_full  = (mq.size() == DEPTH);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: tx/busy/full/cnt got %b/%b/%b/%0d expected 1/0/0/0", tx, busy, full, fifo_count);
    end
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: tx/busy got %b/%b expected 1/0", i, tx, busy);
      end
    end
  endtask

  task automatic test_single();
    int n;
    int done_edge;
    step(1'b1, 8'h41);
    n = edge_no;
    done_edge = -1;
    for (int i = 0; i < NB * DIV + 8; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count || full !== e_full) begin
        errors++;
        $display("FAIL single cyc %0d: tx/busy/cnt/full got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                 i, tx, busy, fifo_count, full, e_tx, e_busy, e_count, e_full);
      end
      if (edge_no == n + 1) begin
        checks++;
        if (tx !== 1'b0) begin
          errors++;
          $display("FAIL single_latency: tx got %b expected 0 after edge N+1", tx);
        end
      end
      if (done_edge < 0 && edge_no > n + 1 && busy === 1'b0) done_edge = edge_no;
    end
    checks++;
    if (done_edge != n + 1 + NB * DIV) begin
      errors++;
      $display("FAIL single_length: busy fell at edge %0d expected %0d", done_edge, n + 1 + NB * DIV);
    end
  endtask

  task automatic test_back_to_back();
    int w0;
    int done_edge;
    done_edge = -1;
    w0 = edge_no + 1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'h30 + 8'(i));
      checks++;
      if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count || full !== e_full) begin
        errors++;
        $display("FAIL b2b_write %0d: tx/busy/cnt/full got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                 i, tx, busy, fifo_count, full, e_tx, e_busy, e_count, e_full);
      end
      if (i == 4) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL b2b_full: full got %b expected 1 after fifth write", full);
        end
      end
    end
    for (int i = 0; i < 6 * NB * DIV; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count || full !== e_full) begin
        errors++;
        $display("FAIL b2b cyc %0d: tx/busy/cnt/full got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                 i, tx, busy, fifo_count, full, e_tx, e_busy, e_count, e_full);
      end
      if (done_edge < 0 && busy === 1'b0) done_edge = edge_no;
    end
    checks++;
    if (done_edge != w0 + 1 + 5 * NB * DIV) begin
      errors++;
      $display("FAIL b2b_contiguous: busy fell at edge %0d expected %0d", done_edge, w0 + 1 + 5 * NB * DIV);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    step(1'b1, 8'hA5);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    guard = 0;
    while (!(m_active && fr_data == 8'hA5 && (edge_no - fr_start) == 4 * DIV + DIV / 2) && guard < 8 * DIV) begin
      step(1'b0, 8'h00);
      guard++;
      checks++;
      if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count) begin
        errors++;
        $display("FAIL resetmid_pre cyc %0d: tx/busy/cnt got %b/%b/%0d expected %b/%b/%0d",
                 guard, tx, busy, fifo_count, e_tx, e_busy, e_count);
      end
    end
    checks++;
    if (guard >= 8 * DIV) begin
      errors++;
      $display("FAIL resetmid_reach: D3 of 0xA5 not reached in %0d cycles", guard);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL resetmid_async: tx/busy/cnt/full got %b/%b/%0d/%b expected 1/0/0/0", tx, busy, fifo_count, full);
    end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2 * NB * DIV; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
        errors++;
        $display("FAIL resetmid_after cyc %0d: tx/busy/cnt got %b/%b/%0d expected 1/0/0", i, tx, busy, fifo_count);
      end
    end
  endtask

  task automatic test_collision();
    int guard;
    for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i));
    guard = 0;
    while (edge_no + 1 < fr_start + NB * DIV && guard < 2 * NB * DIV) begin
      step(1'b0, 8'h00);
      guard++;
    end
    step(1'b1, 8'h55);
    checks++;
    if (fifo_count !== 3'd3 || full !== 1'b0) begin
      errors++;
      $display("FAIL collision: cnt/full got %0d/%b expected 3/0", fifo_count, full);
    end
    for (int i = 0; i < 5 * NB * DIV; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count || full !== e_full) begin
        errors++;
        $display("FAIL collision_drain cyc %0d: tx/busy/cnt/full got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                 i, tx, busy, fifo_count, full, e_tx, e_busy, e_count, e_full);
      end
    end
  endtask

  task automatic test_random();
    int thr;
    logic we;
    for (int p = 0; p < 8; p++) begin
      thr = $urandom_range(0, 4);
      for (int i = 0; i < 500; i++) begin
        we = ($urandom_range(0, 15) < 4 * thr) ? 1'b1 : 1'b0;
        step(we, 8'($urandom));
        checks++;
        if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count || full !== e_full) begin
          errors++;
          $display("FAIL random p%0d cyc %0d: tx/busy/cnt/full got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                   p, i, tx, busy, fifo_count, full, e_tx, e_busy, e_count, e_full);
        end
      end
    end
    for (int i = 0; i < 6 * NB * DIV; i++) begin
      step(1'b0, 8'($urandom));
      checks++;
      if (tx !== e_tx || busy !== e_busy || fifo_count !== e_count || full !== e_full) begin
        errors++;
        $display("FAIL random_drain cyc %0d: tx/busy/cnt/full got %b/%b/%0d/%b expected %b/%b/%0d/%b",
                 i, tx, busy, fifo_count, full, e_tx, e_busy, e_count, e_full);
      end
    end
  endtask

`ifdef BT_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vals [2];
    logic       pexp [2];
    int         n;
    int         done_edge;
    vals[0] = 8'h07; pexp[0] = 1'b1;
    vals[1] = 8'h03; pexp[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      step(1'b1, vals[v]);
      n = edge_no;
      done_edge = -1;
      for (int i = 0; i < NB * DIV + 4; i++) begin
        step(1'b0, 8'($urandom));
        if (edge_no == n + 1 + 9 * DIV + DIV / 2) begin
          checks++;
          if (tx !== pexp[v]) begin
            errors++;
            $display("FAIL parity_bit %0h: tx got %b expected %b", vals[v], tx, pexp[v]);
          end
        end
        if (done_edge < 0 && edge_no > n + 1 && busy === 1'b0) done_edge = edge_no;
      end
      checks++;
      if (done_edge != n + 1 + 11 * DIV) begin
        errors++;
        $display("FAIL parity_length %0h: busy fell at edge %0d expected %0d", vals[v], done_edge, n + 1 + 11 * DIV);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_collision();
    test_random();
`ifdef BT_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
